stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N:1 stream multiplexer, successor to the 2:1 combinational mux. It selects one of N valid/ready input channels, either by an external select or by round-robin arbitration. It holds the grant for a whole packet (until `last`) and drives a registered valid/ready output. It sits between multiple producers and a single downstream consumer in the datapath.

## Interface
- `WIDTH`, 8, data width per channel.
- `N`, 4, number of input channels (≥2, need not be a power of two).
- `SELW`, derived $clog2(N), width of select and channel-ID fields.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = manual select via `sel`, 1 = round-robin.
- `sel`  in  SELW  channel to grant in manual mode.
- `in_data`  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_last`  in  N  per-channel end-of-packet flag.
- `in_ready`  out  N  per-channel ready; at most one bit high.
- `out_data`  out  WIDTH  registered output data.
- `out_valid`  out  1  registered output valid.
- `out_last`  out  1  registered end-of-packet.
- `out_ch`  out  SELW  source channel of the current output beat.
- `out_ready`  in  1  downstream ready.

## Operation
- FSM states:
  - IDLE: no packet in progress.
  - LOCKED: mid-packet, grant fixed to `lock_ch`.
- Round-robin pointer `ptr` (0..N-1).
- Load enable: `load_en = !out_valid || out_ready`.
- Grant in IDLE (combinational):
  - mode=0: grant `sel` if `sel < N` and `in_valid[sel]`; otherwise no grant.
  - mode=1: first k with `in_valid[k]`, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1`; no grant if none valid.
- Grant in LOCKED: always `lock_ch`. `sel` and `mode` are ignored until IDLE.
- `in_ready[g] = load_en` for the granted channel g; all other bits are 0.
- Accept occurs when `in_valid[g] && in_ready[g]`. On accept:
  - `out_data <= in_data[g]`, `out_last <= in_last[g]`, `out_ch <= g`, `out_valid <= 1`.
  - If `in_last[g]`=1: go to IDLE and set `ptr <= (g==N-1) ? 0 : g+1`. A single-beat packet never enters LOCKED.
  - Else: go to LOCKED with `lock_ch <= g`.
- When `out_ready`=1 and there is no accept, `out_valid <= 0`.
- While `out_valid && !out_ready`, all out_* outputs hold stable and `in_ready` is all zero.
- `ptr` updates only on the last beat of a packet. It is also updated in manual mode, so that switching to round-robin resumes fairly.
- A lone active channel is re-granted back-to-back with no idle cycle.

## Timing
- Reset (async assert, sync release). All of the following are forced while `rst_n`=0:
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_ch`=0.
  - `in_ready`=0.
  - State = IDLE, `ptr`=0, `lock_ch`=0.
- Reset mid-packet: the partial packet is abandoned, with no further beats emitted. After reset the FSM arbitrates from `ptr`=0.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1.
- Throughput: 1 beat/cycle when `out_ready` is held at 1, including across packet boundaries.
- `in_ready` is combinational from `in_valid`, `sel`, `mode`, FSM state, `out_valid` and `out_ready`. There is no combinational path from `in_data` to any output.
- Simultaneous events:
  - A downstream pop and an upstream accept in the same cycle replace the output register with no bubble.
  - A `sel` change in the same cycle as the last beat takes effect for the next grant.

## Test plan
- Reset: hold `rst_n`=0 with all `in_valid`=1 -> `out_valid`=0, `in_ready`=4'b0000, `out_data`=0. Release rst_n, mode=1 -> first grant to ch0.
- Manual mode (N=4, WIDTH=8), mode=0, sel=2, ch2 sends single-beat 8'hA5 with last=1, out_ready=1 -> `in_ready`=4'b0100. Next cycle `out_data`=8'hA5, `out_ch`=2, `out_last`=1.
- Round-robin fairness: all four channels continuously valid with single-beat packets, out_ready=1 -> `out_ch` sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Packet lock: ch1 sends 3 beats (11,12,13, last on 13) while ch0/ch3 are valid, mode=1, ptr=1 -> output 11,12,13 all with `out_ch`=1. Next grant is ch3. Changing sel/mode mid-packet has no effect.
- Backpressure: out_ready=0 for 3 cycles with an output beat pending -> out_* stable and `in_ready`=0. Raising out_ready pops the pending beat and accepts the next beat in the same cycle.
- Reset mid-packet, plus an invalid sel: assert rst_n after beat 1 of a 3-beat ch2 packet -> outputs cleared and `ptr`=0. Then mode=0, sel=3 with N=3 -> no grant, `in_ready`=0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with manual select or round-robin arbitration.
// Grant is held for a whole packet (until last) and the output stage is a
// registered valid/ready slice, so in_data never reaches an output
// combinationally.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   mode, sel              0 = manual grant of sel, 1 = round-robin
//   in_data/valid/last     N input channels, channel k at [k*WIDTH +: WIDTH]
//   in_ready               per-channel ready, at most one bit high
//   out_data/valid/last    registered output beat
//   out_ch                 source channel of the current output beat
//   out_ready              downstream ready
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic [SELW-1:0]    out_ch,
    input  logic               out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   lock_q, lock_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [SELW-1:0]   ch_q, ch_d;

    logic              gnt_vld;
    logic [SELW-1:0]   gnt_ch;
    logic [WIDTH-1:0]  gnt_data;
    logic              gnt_last;
    logic              load_en;
    logic              accept;
    logic [SELW-1:0]   ptr_nxt;

    // Output slot is free when empty or being popped this cycle.
    assign load_en = !valid_q || out_ready;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        if (state_q == LOCKED) begin
            gnt_vld = 1'b1;
            gnt_ch  = lock_q;
        end else if (!mode) begin
            // Out-of-range sel simply never matches a channel.
            for (int k = 0; k < N; k++) begin
                if (sel == SELW'(k) && in_valid[k]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = SELW'(k);
                end
            end
        end else begin
            // Scan farthest-first so the nearest valid channel after ptr wins.
            for (int i = N - 1; i >= 0; i--) begin
                idx = int'(ptr_q) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (in_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = SELW'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (gnt_ch == SELW'(k)) begin
                gnt_data = in_data[k*WIDTH +: WIDTH];
                gnt_last = in_last[k];
            end
        end
    end

    assign accept = gnt_vld && load_en && in_valid[gnt_ch];

    assign ptr_nxt = (int'(gnt_ch) == N - 1) ? '0 : gnt_ch + SELW'(1);

    // Reset also masks ready so no producer sees a handshake during reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && gnt_vld && load_en) begin
            in_ready[gnt_ch] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        ch_d    = ch_q;
        if (accept) begin
            data_d  = gnt_data;
            last_d  = gnt_last;
            ch_d    = gnt_ch;
            valid_d = 1'b1;
            if (gnt_last) begin
                state_d = IDLE;
                ptr_d   = ptr_nxt;
            end else begin
                state_d = LOCKED;
                lock_d  = gnt_ch;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: directed scenarios plus random traffic,
// all checked against a packet-level reference model.
module tb_stream_mux_rr;

    localparam int W = 8;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mode;
    logic [1:0]        sel;
    logic [N-1:0][W-1:0] din;
    logic [N-1:0]      vld;
    logic [N-1:0]      lst;
    logic [N-1:0]      rdy;
    logic [W-1:0]      odata;
    logic              ovld;
    logic              olast;
    logic [1:0]        och;
    logic              out_ready;

    logic [1:0]        sel3;
    logic [2:0]        rdy3;
    logic [W-1:0]      od3;
    logic              ov3;
    logic              ol3;
    logic [1:0]        oc3;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (din),
        .in_valid  (vld),
        .in_last   (lst),
        .in_ready  (rdy),
        .out_data  (odata),
        .out_valid (ovld),
        .out_last  (olast),
        .out_ch    (och),
        .out_ready (out_ready)
    );

    stream_mux_rr #(.WIDTH(W), .N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (1'b0),
        .sel       (sel3),
        .in_data   (24'h030201),
        .in_valid  (3'b111),
        .in_last   (3'b111),
        .in_ready  (rdy3),
        .out_data  (od3),
        .out_valid (ov3),
        .out_last  (ol3),
        .out_ch    (oc3),
        .out_ready (1'b1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: output slot, open packet owner (-1 = none), rr pointer.
    bit       m_vld;
    bit       m_last;
    int       m_ch;
    logic [W-1:0] m_data;
    int       m_lock;
    int       m_ptr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_vld  = 0;
        m_last = 0;
        m_ch   = 0;
        m_data = '0;
        m_lock = -1;
        m_ptr  = 0;
    endfunction

    function automatic int exp_grant();
        if (m_lock >= 0) return m_lock;
        if (!mode) begin
            if (int'(sel) < N && vld[sel]) return int'(sel);
            return -1;
        end
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (vld[k]) return k;
        end
        return -1;
    endfunction

    // One clock: check comb ready and registered outputs, then advance model.
    task automatic step();
        int g;
        bit load;
        logic [31:0] er;
        #1;
        if (!rst_n) model_reset();
        g    = exp_grant();
        load = !m_vld || out_ready;
        er   = (rst_n && g >= 0 && load) ? (32'd1 << g) : 32'd0;
        chk("in_ready", rdy, er);
        chk("out_valid", ovld, m_vld);
        chk("out_data", odata, m_data);
        chk("out_last", olast, m_last);
        chk("out_ch", och, m_ch);
        @(posedge clk);
        if (rst_n && g >= 0 && load && vld[g]) begin
            m_vld  = 1;
            m_data = din[g];
            m_last = lst[g];
            m_ch   = g;
            if (lst[g]) begin
                m_lock = -1;
                m_ptr  = (g + 1) % N;
            end else begin
                m_lock = g;
            end
        end else if (rst_n && out_ready) begin
            m_vld = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        sel3      = 2'd3;
        vld       = 4'hF;
        lst       = 4'hF;
        din       = 32'h44332211;
        out_ready = 1'b1;

        // Reset with all channels valid.
        @(negedge clk);
        step();
        step();
        chk("rst_ready", rdy, 0);
        chk("rst_data", odata, 0);
        chk("rst_valid", ovld, 0);

        // Release: first grant to ch0, then round-robin with no bubbles.
        rst_n = 1'b1;
        #1 chk("first_grant", rdy, 4'b0001);
        chk("n3_bad_sel", rdy3, 3'b000);
        for (int i = 0; i < 6; i++) begin
            din = $urandom;
            step();
            chk("rr_ch", och, i % 4);
            chk("rr_vld", ovld, 1);
        end

        // Manual single-beat packet from ch2.
        mode   = 1'b0;
        sel    = 2'd2;
        vld    = 4'b0100;
        lst    = 4'b0100;
        din[2] = 8'hA5;
        #1 chk("man_ready", rdy, 4'b0100);
        step();
        chk("man_data", odata, 8'hA5);
        chk("man_ch", och, 2);
        chk("man_last", olast, 1);

        // Bring ptr to 1: reset, then a single-beat ch0 packet.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mode  = 1'b1;
        vld   = 4'b0001;
        lst   = 4'b0001;
        step();

        // Three-beat ch1 packet while ch0/ch3 also request.
        vld    = 4'b1011;
        lst    = 4'b1001;
        din[1] = 8'd11;
        step();
        chk("lock_b1", odata, 8'd11);
        chk("lock_ch1", och, 1);
        mode   = 1'b0;
        sel    = 2'd3;
        din[1] = 8'd12;
        step();
        chk("lock_b2", odata, 8'd12);
        chk("lock_ch2", och, 1);
        mode   = 1'b1;
        din[1] = 8'd13;
        lst    = 4'b1011;
        step();
        chk("lock_b3", odata, 8'd13);
        chk("lock_ch3", och, 1);
        chk("lock_last", olast, 1);
        step();
        chk("after_lock_ch", och, 3);

        // Backpressure with a beat pending.
        out_ready = 1'b0;
        vld       = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", rdy, 0);
            chk("bp_ch", och, 3);
            chk("bp_vld", ovld, 1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release", rdy, 4'b0001);
        step();
        chk("bp_next_ch", och, 0);

        // Reset in the middle of a ch2 packet.
        mode   = 1'b0;
        sel    = 2'd2;
        vld    = 4'b0100;
        lst    = 4'b0000;
        din[2] = 8'h21;
        step();
        chk("mid_b1", odata, 8'h21);
        rst_n = 1'b0;
        #1 chk("mid_rst_vld", ovld, 0);
        chk("mid_rst_data", odata, 0);
        step();
        rst_n = 1'b1;
        vld   = 4'b0000;
        step();
        chk("mid_after_vld", ovld, 0);
        mode = 1'b1;
        vld  = 4'hF;
        lst  = 4'hF;
        #1 chk("mid_ptr0", rdy, 4'b0001);
        step();

        // N=3 instance: sel=3 never grants, sel=1 does.
        chk("n3_sel3", rdy3, 3'b000);
        sel3 = 2'd1;
        #1 chk("n3_sel1", rdy3, 3'b010);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            mode      = $urandom_range(0, 1) == 1;
            sel       = 2'($urandom_range(0, 3));
            vld       = 4'($urandom);
            lst       = 4'($urandom) & 4'($urandom);
            din       = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
